// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART constants and receiver state encoding.
// Holds the default bit period so the receiver and transmitter agree.
package uart_rx_pkg;

   // 100 MHz / 115200 baud
   localparam int UART_DIV = 868;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets high.
// Ports: clk, rst (sync, active-high), i_d (async in), o_q (synced out).
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   // Reset to the idle level so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, valid/ack output.
// Ports: clk, rst, Rx_i, ack_i -> data_o, valid_o, frame_err_o,
//        overrun_o (sticky until ack), busy_o (inside a frame).
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DIV = UART_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Rx_i,
   input  logic       ack_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);

   logic            w_rx_s;
   rx_state_t       r_state;
   logic [CW-1:0]   r_cnt;
   logic [3:0]      r_idx;
   logic [7:0]      r_shift;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_ferr;
   logic            r_ovr;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (Rx_i),
      .o_q (w_rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         // Accepted ack; a byte completing this cycle overrides valid below
         if (r_valid && ack_i) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
         end
         unique case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  r_state <= START;
                  r_cnt   <= '0;
               end
            end
            START: begin
               // Re-check at mid start bit to reject short glitches
               if (r_cnt == HALF) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= w_rx_s ? IDLE : DATA;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DATA: begin
               if (r_cnt == FULL) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rx_s, r_shift[7:1]};
                  r_idx   <= r_idx + 4'd1;
                  if (r_idx == 4'd7) r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            STOP: begin
               if (r_cnt == FULL) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     r_data  <= r_shift;
                     r_valid <= 1'b1;
                     if (r_valid && !ack_i) r_ovr <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            BREAK: begin
               // Held-low line must return high before a new frame
               if (w_rx_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_ferr;
   assign overrun_o   = r_ovr;
   assign busy_o      = (r_state != IDLE);

endmodule
